spi_responder: RTL and testbench
================================

SPI_RESPONDER -- requirements
Module: spi_responder

Interface
REQ-001 Parameter WORD_WIDTH, default 8, width of address and data bytes; one transfer is 2*WORD_WIDTH bits.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchroniser flops on SCLK, CS and MOSI.
REQ-003 i_clock  input  1  the single system clock; all state is on its rising edge.
REQ-004 i_reset  input  1  reset, synchronous and active-high.
REQ-005 SCLK  input  1  SPI clock from the initiator, CPOL=0/CPHA=0, asynchronous to i_clock.
REQ-006 CS  input  1  chip select, active low, asynchronous.
REQ-007 MOSI  input  1  serial data in, MSB first.
REQ-008 MISO  output  1  serial data out, MSB first.
REQ-009 o_rd_req  output  1  one-cycle pulse requesting read data.
REQ-010 o_rd_addr  output  WORD_WIDTH-1  register address for the read.
REQ-011 i_rd_data  input  WORD_WIDTH  read data, sampled exactly one i_clock after o_rd_req.
REQ-012 o_wr_valid  output  1  one-cycle pulse on a completed write.
REQ-013 o_wr_addr  output  WORD_WIDTH-1  write address, valid with o_wr_valid.
REQ-014 o_wr_data  output  WORD_WIDTH  write data, valid with o_wr_valid.
REQ-015 o_abort  output  1  one-cycle pulse when CS deasserts mid-transfer.
REQ-016 busy  output  1  high whenever the FSM is not IDLE.
REQ-017 i_status  input  WORD_WIDTH  status byte shifted out during the upper byte (only with SPI_RESP_STATUS_EN).

Function
REQ-018 SCLK, CS and MOSI SHALL pass through SYNC_STAGES flops; edges are detected on the synchronised signals; i_clock SHALL be at least 8x the SCLK frequency.
REQ-019 FSM states: IDLE, ADDR, DATA, DONE. IDLE->ADDR on synchronised CS falling edge, bit counter cleared.
REQ-020 In ADDR/DATA each synchronised SCLK rising edge shifts MOSI into rx shift register LSB and increments the bit counter.
REQ-021 After the 8th rising edge: address byte latched; bit 7 = 1 means read, 0 means write; ADDR->DATA.
REQ-022 On read, o_rd_req pulses the cycle after the 8th edge is detected with o_rd_addr = address[6:0]; i_rd_data is loaded into the tx shift register on the next cycle.
REQ-023 On write, the tx shift register is loaded with zero at the same point.
REQ-024 MISO updates only on synchronised SCLK falling edges; the tx shift register shifts left one bit per falling edge; MISO = tx_shift[MSB].
REQ-025 After the 16th rising edge: DATA->DONE; on write, o_wr_valid pulses with o_wr_addr = address[6:0] and o_wr_data = the lower byte.
REQ-026 DONE->IDLE on CS rising edge; SCLK edges in DONE are ignored and MISO is held 0.
REQ-027 CS rising in ADDR or DATA: o_abort pulses one cycle, no o_wr_valid is issued, FSM -> IDLE; an o_rd_req already issued is not retracted.
REQ-028 CS high: MISO = 0, counters held clear; a CS falling edge coincident with the DONE->IDLE transition is honoured on the next cycle.

Reset
REQ-029 i_reset SHALL force IDLE, clear shift registers, counter and synchronisers to idle levels (CS=1, SCLK=0).
REQ-030 Reset values: MISO=0, o_rd_req=0, o_wr_valid=0, o_abort=0, busy=0, o_rd_addr=0, o_wr_addr=0, o_wr_data=0.
REQ-031 Reset mid-transfer discards the transfer silently (no o_abort); the next transfer requires a fresh CS falling edge.

Configuration
REQ-032 Macro SPI_RESP_STATUS_EN: when defined, i_status is loaded into tx_shift on CS falling and shifted out during the upper byte; when undefined, i_status is absent and MISO is 0 for the upper byte.

Structure
REQ-033 FSM state encoding and READ_FLAG bit position (7) SHALL live in shared package spi_pkg, also usable by the initiator.
REQ-034 The synchroniser-plus-edge-detector SHALL be sub-module spi_edge_sync (one instance per input).

Verification
REQ-035 Write: CS low, shift 0x05,0xA7 at SCLK = i_clock/16 -> one o_wr_valid, addr=0x05, data=0xA7; no o_rd_req.
REQ-036 Read: shift 0x85,0x00 with i_rd_data=0x3C -> o_rd_req with addr=0x05; MISO bits 9-16 = 0x3C; no o_wr_valid.
REQ-037 Abort: CS rises after 11 SCLK edges of write 0x12,0xFF -> o_abort pulse, no o_wr_valid, busy=0 within 4 cycles.
REQ-038 Status (macro defined): i_status=0x5A, read 0x81 -> MISO upper byte 0x5A; macro undefined -> 0x00.
REQ-039 Back-to-back: two writes with CS high for 2 SCLK periods -> two o_wr_valid pulses, correct values; reset asserted mid-read -> no strobes, all outputs at reset values.

Source files
------------

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI responder and any matching initiator model:
// transfer FSM state encoding and the position of the read/write flag in the
// address byte.
// Ports: none (package).
// Optional feature macro used by the responder: SPI_RESP_STATUS_EN.
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } spi_state_t;

    // The read flag is the MSB of the address byte.
    function automatic int read_flag_pos(input int word_width);
        return word_width - 1;
    endfunction

    localparam int READ_FLAG = read_flag_pos(8);

endpackage

// File: rtl/spi_responder_if.sv
// -----------------------------------------------------------------------------
// spi_responder_if
// Register-side bus between the SPI responder and a register file.
//   o_rd_req   : one-cycle read request
//   o_rd_addr  : read address (WORD_WIDTH-1 bits)
//   i_rd_data  : read data, sampled one cycle after o_rd_req
//   o_wr_valid : one-cycle write strobe
//   o_wr_addr  : write address (WORD_WIDTH-1 bits)
//   o_wr_data  : write data
// Modports: master = responder side, slave = register file side.
// -----------------------------------------------------------------------------
interface spi_responder_if #(
    parameter int WORD_WIDTH = 8
);

    logic                  o_rd_req;
    logic [WORD_WIDTH-2:0] o_rd_addr;
    logic [WORD_WIDTH-1:0] i_rd_data;
    logic                  o_wr_valid;
    logic [WORD_WIDTH-2:0] o_wr_addr;
    logic [WORD_WIDTH-1:0] o_wr_data;

    modport master (
        output o_rd_req, o_rd_addr, o_wr_valid, o_wr_addr, o_wr_data,
        input  i_rd_data
    );

    modport slave (
        input  o_rd_req, o_rd_addr, o_wr_valid, o_wr_addr, o_wr_data,
        output i_rd_data
    );

endinterface

// File: rtl/spi_edge_sync.sv
// -----------------------------------------------------------------------------
// spi_edge_sync
// Multi-flop synchroniser for one asynchronous input followed by a rising /
// falling edge detector on the synchronised level.
//   i_clock    : system clock
//   i_reset    : synchronous active-high reset (chain forced to IDLE_LEVEL)
//   i_async    : asynchronous input
//   o_level    : synchronised level
//   o_rise     : one-cycle pulse on a synchronised 0->1 transition
//   o_fall     : one-cycle pulse on a synchronised 1->0 transition
// -----------------------------------------------------------------------------
module spi_edge_sync #(
    parameter int   STAGES     = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sync_q <= {STAGES{IDLE_LEVEL}};
            prev_q <= IDLE_LEVEL;
        end else begin
            // Truncating cast keeps this valid for a single-stage chain.
            sync_q <= STAGES'({sync_q, i_async});
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign o_level = sync_q[STAGES-1];
    assign o_rise  = o_level & ~prev_q;
    assign o_fall  = ~o_level & prev_q;

endmodule

// File: rtl/spi_responder.sv
// -----------------------------------------------------------------------------
// spi_responder
// SPI (CPOL=0/CPHA=0) responder. A transfer is an address byte (MSB = read
// flag) followed by a data byte. Reads request data from a register file and
// return it on MISO during the data byte; writes strobe address and data out.
//   i_clock  : system clock (>= 8x SCLK)
//   i_reset  : synchronous active-high reset
//   SCLK, CS, MOSI : asynchronous SPI inputs (CS active low)
//   MISO     : serial data out, MSB first, 0 outside ADDR/DATA
//   i_status : status byte returned during the address byte
//              (present only when SPI_RESP_STATUS_EN is defined)
//   o_abort  : one-cycle pulse when CS rises mid-transfer
//   busy     : high whenever the FSM is not idle
//   reg_bus  : register-side read/write bus (spi_responder_if.master)
// Optional feature macro: SPI_RESP_STATUS_EN.
//
// state | meaning
// IDLE  | waiting for CS falling edge
// ADDR  | shifting in the address byte
// DATA  | shifting in/out the data byte
// DONE  | transfer complete, waiting for CS to rise
// -----------------------------------------------------------------------------
module spi_responder
    import spi_pkg::*;
#(
    parameter int WORD_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  SCLK,
    input  logic                  CS,
    input  logic                  MOSI,
    output logic                  MISO,
`ifdef SPI_RESP_STATUS_EN
    input  logic [WORD_WIDTH-1:0] i_status,
`endif
    output logic                  o_abort,
    output logic                  busy,
    spi_responder_if.master       reg_bus
);

    localparam int CNT_W   = $clog2(2 * WORD_WIDTH + 1);
    localparam int BLANK_W = $clog2(SYNC_STAGES + 2);
    localparam int RD_BIT  = read_flag_pos(WORD_WIDTH);

    localparam logic [CNT_W-1:0]   ADDR_LAST = CNT_W'(WORD_WIDTH - 1);
    localparam logic [CNT_W-1:0]   DATA_LAST = CNT_W'(2 * WORD_WIDTH - 1);
    localparam logic [CNT_W-1:0]   BYTE_EDGE = CNT_W'(WORD_WIDTH);
    localparam logic [BLANK_W-1:0] BLANK_INIT = BLANK_W'(SYNC_STAGES + 1);

    spi_state_t state, state_next;

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level, mosi_rise, mosi_fall;

    logic [CNT_W-1:0]      bit_cnt;
    logic [WORD_WIDTH-1:0] rx_shift;
    logic [WORD_WIDTH-1:0] rx_word;
    logic [WORD_WIDTH-1:0] tx_shift;
    logic [WORD_WIDTH-1:0] addr_byte;
    logic                  rd_load;
    logic [BLANK_W-1:0]    blank_cnt;

    logic in_xfer, start, abort, last_addr_bit, last_data_bit;

    spi_edge_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_sclk (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_async (SCLK),
        .o_level (sclk_level),
        .o_rise  (sclk_rise),
        .o_fall  (sclk_fall)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_cs (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_async (CS),
        .o_level (cs_level),
        .o_rise  (cs_rise),
        .o_fall  (cs_fall)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_mosi (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_async (MOSI),
        .o_level (mosi_level),
        .o_rise  (mosi_rise),
        .o_fall  (mosi_fall)
    );

    assign in_xfer = (state == ST_ADDR) || (state == ST_DATA);
    // After reset the CS chain flushes its idle 1 out; if CS was held low
    // through reset that looks like a falling edge, so it is blanked until a
    // genuinely new edge can arrive.
    assign start   = (state == ST_IDLE) && cs_fall && (blank_cnt == '0);
    assign abort   = in_xfer && cs_rise;
    assign rx_word = {rx_shift[WORD_WIDTH-2:0], mosi_level};

    assign last_addr_bit = (state == ST_ADDR) && sclk_rise && !cs_rise
                           && (bit_cnt == ADDR_LAST);
    assign last_data_bit = (state == ST_DATA) && sclk_rise && !cs_rise
                           && (bit_cnt == DATA_LAST);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start)              state_next = ST_ADDR;
            ST_ADDR: if (cs_rise)            state_next = ST_IDLE;
                     else if (last_addr_bit) state_next = ST_DATA;
            ST_DATA: if (cs_rise)            state_next = ST_IDLE;
                     else if (last_data_bit) state_next = ST_DONE;
            ST_DONE: if (cs_rise)            state_next = ST_IDLE;
            default:                         state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
        MISO = 1'b0;
        if (in_xfer) begin
            MISO = tx_shift[WORD_WIDTH-1];
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            bit_cnt            <= '0;
            rx_shift           <= '0;
            tx_shift           <= '0;
            addr_byte          <= '0;
            rd_load            <= 1'b0;
            blank_cnt          <= BLANK_INIT;
            o_abort            <= 1'b0;
            reg_bus.o_rd_req   <= 1'b0;
            reg_bus.o_rd_addr  <= '0;
            reg_bus.o_wr_valid <= 1'b0;
            reg_bus.o_wr_addr  <= '0;
            reg_bus.o_wr_data  <= '0;
        end else begin
            reg_bus.o_rd_req   <= 1'b0;
            reg_bus.o_wr_valid <= 1'b0;
            o_abort            <= abort;
            rd_load            <= reg_bus.o_rd_req;

            if (blank_cnt != '0) begin
                blank_cnt <= blank_cnt - 1'b1;
            end

            if (cs_level || (state == ST_IDLE)) begin
                bit_cnt <= '0;
            end else if (in_xfer && sclk_rise) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (start) begin
                rx_shift <= '0;
            end else if (in_xfer && sclk_rise && !cs_rise) begin
                rx_shift <= rx_word;
            end

            if (last_addr_bit) begin
                addr_byte <= rx_word;
                if (rx_word[RD_BIT]) begin
                    reg_bus.o_rd_req  <= 1'b1;
                    reg_bus.o_rd_addr <= rx_word[WORD_WIDTH-2:0];
                end
            end

            if (last_data_bit && !addr_byte[RD_BIT]) begin
                reg_bus.o_wr_valid <= 1'b1;
                reg_bus.o_wr_addr  <= addr_byte[WORD_WIDTH-2:0];
                reg_bus.o_wr_data  <= rx_word;
            end

            // The falling edge that closes the address byte must not shift:
            // the data byte has already been loaded and its MSB has to be on
            // MISO for the first data-byte rising edge.
            if (start) begin
`ifdef SPI_RESP_STATUS_EN
                tx_shift <= i_status;
`else
                tx_shift <= '0;
`endif
            end else if (last_addr_bit) begin
                tx_shift <= '0;
            end else if (rd_load && (state == ST_DATA)) begin
                tx_shift <= reg_bus.i_rd_data;
            end else if (in_xfer && sclk_fall && (bit_cnt != BYTE_EDGE)) begin
                tx_shift <= {tx_shift[WORD_WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_spi_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_responder
// Self-checking bench for spi_responder: directed cases with literal
// expectations, then randomized transfers against a transaction-level model.
// Optional feature macro honoured: SPI_RESP_STATUS_EN.
// -----------------------------------------------------------------------------
module tb_spi_responder;

    logic clk;
    logic i_reset;
    logic SCLK, CS, MOSI;
    logic MISO, o_abort, busy;
    logic [7:0] status;

    spi_responder_if #(.WORD_WIDTH(8)) bus ();

    spi_responder #(.WORD_WIDTH(8), .SYNC_STAGES(2)) dut (
        .i_clock  (clk),
        .i_reset  (i_reset),
        .SCLK     (SCLK),
        .CS       (CS),
        .MOSI     (MOSI),
        .MISO     (MISO),
`ifdef SPI_RESP_STATUS_EN
        .i_status (status),
`endif
        .o_abort  (o_abort),
        .busy     (busy),
        .reg_bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [128];
    logic [14:0] exp_wr [$];
    logic [6:0]  exp_rd [$];
    int          exp_abort = 0;

    logic reset_chk = 1'b0;
    logic quiet     = 1'b0;
    logic active    = 1'b0;
    logic miso_win  = 1'b0;
    logic miso_exp  = 1'b0;

    int         wr_seen = 0, rd_seen = 0, abort_seen = 0;
    logic [6:0] last_wr_addr = '0, last_rd_addr = '0;
    logic [7:0] last_wr_data = '0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [15:0] model_miso(input logic [7:0] a);
        logic [7:0] hi;
        logic [7:0] lo;
        hi = 8'h00;
`ifdef SPI_RESP_STATUS_EN
        hi = status;
`endif
        lo = a[7] ? mem[a[6:0]] : 8'h00;
        return {hi, lo};
    endfunction

    // Register file: answers a read request with data valid for exactly the
    // following cycle, random garbage at all other times.
    initial begin
        logic       req_seen;
        logic [6:0] req_addr;
        bus.i_rd_data = 8'h00;
        forever begin
            @(negedge clk);
            req_seen = bus.o_rd_req;
            req_addr = bus.o_rd_addr;
            @(posedge clk);
            #1;
            bus.i_rd_data = req_seen ? mem[req_addr] : 8'($urandom);
        end
    end

    // Compare process.
    initial begin
        logic [14:0] ew;
        logic [6:0]  er;
        forever begin
            @(posedge clk);
            #2;
            if (reset_chk) begin
                chk("rst_miso", MISO, 0);
                chk("rst_rd_req", bus.o_rd_req, 0);
                chk("rst_wr_valid", bus.o_wr_valid, 0);
                chk("rst_abort", o_abort, 0);
                chk("rst_busy", busy, 0);
                chk("rst_rd_addr", bus.o_rd_addr, 0);
                chk("rst_wr_addr", bus.o_wr_addr, 0);
                chk("rst_wr_data", bus.o_wr_data, 0);
            end else begin
                if (bus.o_wr_valid) begin
                    wr_seen++;
                    last_wr_addr = bus.o_wr_addr;
                    last_wr_data = bus.o_wr_data;
                    chk("wr_expected", exp_wr.size() > 0, 1);
                    if (exp_wr.size() > 0) begin
                        ew = exp_wr.pop_front();
                        chk("wr_addr", bus.o_wr_addr, ew[14:8]);
                        chk("wr_data", bus.o_wr_data, ew[7:0]);
                    end
                end
                if (bus.o_rd_req) begin
                    rd_seen++;
                    last_rd_addr = bus.o_rd_addr;
                    chk("rd_expected", exp_rd.size() > 0, 1);
                    if (exp_rd.size() > 0) begin
                        er = exp_rd.pop_front();
                        chk("rd_addr", bus.o_rd_addr, er);
                    end
                end
                if (o_abort) begin
                    abort_seen++;
                    chk("abort_expected", exp_abort > 0, 1);
                    if (exp_abort > 0) exp_abort--;
                end
                if (miso_win) chk("miso_bit", MISO, miso_exp);
                if (quiet) begin
                    chk("idle_busy", busy, 0);
                    chk("idle_miso", MISO, 0);
                end
                if (active) chk("active_busy", busy, 1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        i_reset = 1'b1;
        quiet   = 1'b1;
        @(negedge clk);
        reset_chk = 1'b1;
        repeat (3) @(negedge clk);
        reset_chk = 1'b0;
        i_reset   = 1'b0;
    endtask

    // One transfer of nbits SCLK periods (16 = complete, fewer = aborted),
    // followed by CS high for cs_high cycles. Returns MISO as sampled by the
    // initiator just before each rising edge.
    task automatic xfer(input logic [7:0] a, input logic [7:0] d,
                        input int nbits, input int cs_high,
                        output logic [15:0] cap);
        logic [15:0] word;
        logic [15:0] expm;
        word = {a, d};
        expm = model_miso(a);
        cap  = '0;
        @(negedge clk);
        quiet = 1'b0;
        CS    = 1'b0;
        repeat (8) @(negedge clk);
        active = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            MOSI = word[15-i];
            repeat (4) @(negedge clk);
            miso_exp = expm[15-i];
            miso_win = 1'b1;
            repeat (4) @(negedge clk);
            cap[15-i] = MISO;
            miso_win  = 1'b0;
            SCLK      = 1'b1;
            if (i == 7 && a[7])   exp_rd.push_back(a[6:0]);
            if (i == 15 && !a[7]) exp_wr.push_back({a[6:0], d});
            repeat (8) @(negedge clk);
            SCLK = 1'b0;
        end
        if (nbits == 16) begin
            // An extra SCLK pulse in DONE must be ignored with MISO low.
            miso_exp = 1'b0;
            miso_win = 1'b1;
            repeat (4) @(negedge clk);
            miso_win = 1'b0;
            SCLK = 1'b1;
            repeat (8) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (4) @(negedge clk);
        CS     = 1'b1;
        active = 1'b0;
        if (nbits < 16) exp_abort++;
        repeat (4) @(negedge clk);
        quiet = 1'b1;
        repeat (cs_high - 4) @(negedge clk);
        chk("wr_missing", exp_wr.size(), 0);
        chk("rd_missing", exp_rd.size(), 0);
        chk("abort_missing", exp_abort, 0);
    endtask

    task automatic raw_bit(input logic b);
        MOSI = b;
        repeat (8) @(negedge clk);
        SCLK = 1'b1;
        repeat (8) @(negedge clk);
        SCLK = 1'b0;
    endtask

    initial begin
        logic [15:0] cap;
        int w0, r0, a0;
        logic [7:0] a, d;
        int nb;

        i_reset = 1'b1;
        CS      = 1'b1;
        SCLK    = 1'b0;
        MOSI    = 1'b0;
        status  = 8'h00;
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        mem[5] = 8'h3C;
        do_reset();
        repeat (4) @(negedge clk);

        // Write 0x05 <- 0xA7.
        w0 = wr_seen; r0 = rd_seen;
        xfer(8'h05, 8'hA7, 16, 40, cap);
        chk("dir_wr_count", wr_seen - w0, 1);
        chk("dir_wr_addr", last_wr_addr, 7'h05);
        chk("dir_wr_data", last_wr_data, 8'hA7);
        chk("dir_wr_no_rd", rd_seen - r0, 0);
        chk("dir_wr_miso_lo", cap[7:0], 8'h00);

        // Read 0x05 -> 0x3C.
        w0 = wr_seen; r0 = rd_seen;
        xfer(8'h85, 8'h00, 16, 40, cap);
        chk("dir_rd_count", rd_seen - r0, 1);
        chk("dir_rd_addr", last_rd_addr, 7'h05);
        chk("dir_rd_miso", cap[7:0], 8'h3C);
        chk("dir_rd_no_wr", wr_seen - w0, 0);

        // Abort a write after 11 bits.
        w0 = wr_seen; a0 = abort_seen;
        xfer(8'h12, 8'hFF, 11, 40, cap);
        chk("dir_abort_count", abort_seen - a0, 1);
        chk("dir_abort_no_wr", wr_seen - w0, 0);

        // Status byte on the address phase.
        status = 8'h5A;
        repeat (4) @(negedge clk);
        xfer(8'h81, 8'h00, 16, 40, cap);
`ifdef SPI_RESP_STATUS_EN
        chk("dir_status_byte", cap[15:8], 8'h5A);
`else
        chk("dir_status_byte", cap[15:8], 8'h00);
`endif
        chk("dir_status_rd", cap[7:0], mem[1]);

        // Back-to-back writes, CS high for two SCLK periods.
        w0 = wr_seen;
        xfer(8'h21, 8'h3B, 16, 32, cap);
        xfer(8'h7E, 8'hC4, 16, 32, cap);
        chk("b2b_count", wr_seen - w0, 2);
        chk("b2b_last_addr", last_wr_addr, 7'h7E);
        chk("b2b_last_data", last_wr_data, 8'hC4);

        // Reset in the middle of a read: no strobes, nothing until fresh CS.
        w0 = wr_seen; r0 = rd_seen; a0 = abort_seen;
        @(negedge clk);
        quiet = 1'b0;
        CS    = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 5; i++) raw_bit(i == 0);
        do_reset();
        for (int i = 0; i < 11; i++) raw_bit(1'b1);
        CS = 1'b1;
        repeat (32) @(negedge clk);
        chk("rst_mid_wr", wr_seen - w0, 0);
        chk("rst_mid_rd", rd_seen - r0, 0);
        chk("rst_mid_abort", abort_seen - a0, 0);

        // Randomized transfers.
        for (int n = 0; n < 40; n++) begin
            status = 8'($urandom);
            a      = 8'($urandom);
            d      = 8'($urandom);
            nb     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 16;
            repeat (2) @(negedge clk);
            xfer(a, d, nb, int'($urandom_range(32, 60)), cap);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
